// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_queue
//  Description : 32x32 register file fed through a 2-entry in-order
//                write-back queue. Accepted writes are queued and retired
//                into the array one per cycle when the write port is
//                granted (commit_en). Writes to r0 and "no write" requests
//                handshake normally but are dropped.
//                Optional feature macro: RF_BYPASS_EN. When defined, reads
//                see pending queue entries (youngest first); otherwise
//                reads return only committed array contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_queue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [4:0]  wr_rt,
   input  logic [4:0]  wr_rd,
   input  logic [1:0]  wr_dst_sel,
   input  logic [31:0] wr_data,
   input  logic        commit_en,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b,
   output logic        commit_valid,
   output logic [4:0]  commit_addr,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0][4:0]  q_addr_q, q_addr_d;
   logic [1:0][31:0] q_data_q, q_data_d;
   logic [31:0][31:0] regs_q, regs_d;

   logic [4:0]  dst_addr;
   logic        push;
   logic        commit;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   // Read port: r0 is hardwired to zero; with bypass the youngest pending
   // entry wins, then the older one, then the array.
   function automatic logic [31:0] rf_read(input logic [4:0] a);
      logic [31:0] r;
      r = regs_q[a];
`ifdef RF_BYPASS_EN
      if (state_q != ST_EMPTY && q_addr_q[rd_ptr_q] == a)
         r = q_data_q[rd_ptr_q];
      if (state_q == ST_FULL && q_addr_q[~rd_ptr_q] == a)
         r = q_data_q[~rd_ptr_q];
`endif
      if (a == 5'd0)
         r = 32'd0;
      return r;
   endfunction

   // Handshake, destination decode, queue/array next-state and outputs.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      q_addr_d = q_addr_q;
      q_data_d = q_data_q;
      regs_d   = regs_q;

      case (wr_dst_sel)
         2'b00:   dst_addr = wr_rt;
         2'b01:   dst_addr = wr_rd;
         2'b10:   dst_addr = 5'd31;
         default: dst_addr = 5'd0;
      endcase

      // Ready is a pure function of occupancy so it never waits on commit_en.
      wr_ready  = (state_q != ST_FULL);
      busy      = (state_q != ST_EMPTY);
      head_addr = q_addr_q[rd_ptr_q];
      head_data = q_data_q[rd_ptr_q];

      // Dropped requests (r0 or sel=11) still complete the handshake.
      push   = wr_valid && wr_ready && (dst_addr != 5'd0);
      commit = commit_en && (state_q != ST_EMPTY);

      commit_valid = commit;
      commit_addr  = (state_q != ST_EMPTY) ? head_addr : 5'd0;

      if (commit) begin
         regs_d[head_addr] = head_data;
         rd_ptr_d          = ~rd_ptr_q;
      end
      if (push) begin
         q_addr_d[wr_ptr_q] = dst_addr;
         q_data_d[wr_ptr_q] = wr_data;
         wr_ptr_d           = ~wr_ptr_q;
      end

      case (state_q)
         ST_EMPTY: if (push) state_d = ST_ONE;
         ST_ONE: begin
            if (push && !commit)      state_d = ST_FULL;
            else if (!push && commit) state_d = ST_EMPTY;
         end
         ST_FULL:  if (commit) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase

      rd_data_a = rf_read(rd_addr_a);
      rd_data_b = rf_read(rd_addr_b);
   end

   // State, pointers, queue storage and array; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         q_addr_q <= '0;
         q_data_q <= '0;
         regs_q   <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         q_addr_q <= q_addr_d;
         q_data_q <= q_data_d;
         regs_q   <= regs_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port wr_valid, input, 1 bit: write-back request valid.
REQ-004 SHALL have port wr_ready, output, 1 bit: request accepted on any cycle where wr_valid and wr_ready are both 1.
REQ-005 SHALL have ports wr_rt and wr_rd, input, 5 bits each: candidate destination register numbers.
REQ-006 SHALL have port wr_dst_sel, input, 2 bits: destination select; 00 selects wr_rt, 01 selects wr_rd, 10 selects r31, 11 means no write.
REQ-007 SHALL have port wr_data, input, 32 bits: write-back value.
REQ-008 SHALL have port commit_en, input, 1 bit: register-file write port granted this cycle.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, input, 5 bits each: read addresses.
REQ-010 SHALL have ports rd_data_a and rd_data_b, output, 32 bits each: read data.
REQ-011 SHALL have ports commit_valid (output, 1 bit) and commit_addr (output, 5 bits): the register being written this cycle.
REQ-012 SHALL have port busy, output, 1 bit: 1 while the queue is non-empty.

Function
REQ-013 SHALL contain a 32x32-bit register array and a 2-entry in-order pending-write queue; each entry holds a 5-bit address and 32-bit data.
REQ-014 SHALL hold queue state in one of three states: EMPTY, ONE or FULL.
REQ-015 SHALL drive wr_ready = 1 in EMPTY and ONE, and wr_ready = 0 in FULL; wr_ready SHALL NOT depend on commit_en in the same cycle.
REQ-016 SHALL resolve the destination address combinationally from wr_dst_sel at acceptance.
REQ-017 SHALL complete the handshake for an accepted request with destination 0 or wr_dst_sel = 11, but SHALL NOT enqueue it.
REQ-018 SHALL commit on a rising edge when commit_en = 1 and the state is not EMPTY: write the head entry's data into the array at its address, then pop the head.
REQ-019 SHALL drive commit_valid = commit_en AND (state != EMPTY) combinationally, with commit_addr equal to the head address (0 when EMPTY).
REQ-020 SHALL handle state transitions as follows:
  - push only: EMPTY->ONE, ONE->FULL
  - commit only: ONE->EMPTY, FULL->ONE
  - push and commit together in ONE: stay in ONE, with the new entry at the head
  - push and commit together in FULL: not possible
REQ-021 SHALL return 0 on reads of address 0; r0 SHALL never be written.
REQ-022 SHALL make array reads combinational, and a read in the same cycle as a commit to that address SHALL return the old array value, apart from the bypass in REQ-030.
REQ-023 SHALL drive busy = (state != EMPTY).
REQ-024 SHALL keep the ordering that entries commit in acceptance order; two entries to the same address SHALL both commit, and the younger value SHALL remain.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force state EMPTY, queue pointers to 0, and every array word to 0, independent of clk.
REQ-026 SHALL drive wr_ready = 1, commit_valid = 0, commit_addr = 0, busy = 0 and rd_data_a/b = 0 during reset.
REQ-027 SHALL discard pending entries when reset is asserted mid-operation; they SHALL never commit.
REQ-028 SHALL ignore wr_valid and commit_en while rst_n = 0.

Configuration
REQ-029 SHALL use macro RF_BYPASS_EN to select read bypass.
REQ-030 SHALL, when RF_BYPASS_EN is defined, satisfy each nonzero read address from the youngest matching queue entry, else the older matching entry, else the array.
REQ-031 SHALL, when RF_BYPASS_EN is undefined, read the array only; pending entries SHALL be invisible until committed.

Verification
REQ-032 SHALL cover: reset, then read any of addresses 0..31 -> all read 0; wr_ready=1; busy=0.
REQ-033 SHALL cover: push sel=01, wr_rd=5, data 0xDEADBEEF with commit_en=1 -> commit_valid=1 with commit_addr=5 in the next cycle; reading 5 thereafter returns 0xDEADBEEF.
REQ-034 SHALL cover: commit_en=0, push r3=0x11 then r3=0x22 -> FULL and wr_ready=0; read 3 returns 0x22 with RF_BYPASS_EN defined and 0 without; then commit_en=1 for 2 cycles -> array r3=0x22.
REQ-035 SHALL cover: push sel=00 with wr_rt=0, then push sel=11 -> both handshakes complete, busy stays 0, and r0 reads 0.
REQ-036 SHALL cover: in ONE, push sel=10 with data 0x4 and commit together -> state stays ONE, head commits, and r31 becomes 0x4 after the next commit.
REQ-037 SHALL cover: in FULL, assert rst_n=0 mid-cycle -> immediately busy=0 and wr_ready=1; the pending addresses read 0 after reset.
